// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32 core.
// Contents:
//   STAGE_W  - width of the sequencer state / stage code
//   stage_e  - sequencer state codes, also exported on the stage port
package core_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_FT   = 3'd1,
    ST_DC   = 3'd2,
    ST_EX   = 3'd3,
    ST_MA   = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } stage_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running clock-enable divider: asserts tick for one CLK cycle out of
// every DIV cycles (tick is permanently high when DIV=1).
// Ports:
//   CLK    in  system clock
//   RST_N  in  asynchronous active-low reset (counter returns to 0)
//   tick   out high in the cycle where the divider equals DIV-1
module tick_gen #(
  parameter int DIV   = 2,
  parameter int DIV_W = 24
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // With DIV=1 LAST is 0, so the counter sits at 0 and tick stays high.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer for the multi-cycle RV32 core. Replaces gated stage clocks
// with one-cycle enables: every stage register block runs on CLK and loads
// when its EN_x is high. EN_x pulses in the cycle after the tick on which
// stage x completes.
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   run              level, start/continue executing
//   halt_req         level, halt at the next instruction boundary (beats run)
//   memWait          memory not ready, holds FT and MA
//   rwmem            instruction accesses data memory, sampled on the EX tick
//   mem_req          high while in FT or MA
//   mem_is_fetch     1 in FT, 0 in MA
//   EN_FT..EN_WB     one-cycle stage enables
//   instret          one-cycle retire pulse, coincident with EN_WB
//   stage            current state code
//   halted           high while in HALT
//   stall_cnt        saturating count of ticks stalled on memWait
module stage_sequencer
  import core_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int DIV_W = 24
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               run,
  input  logic               halt_req,
  input  logic               memWait,
  input  logic               rwmem,
  output logic               mem_req,
  output logic               mem_is_fetch,
  output logic               EN_FT,
  output logic               EN_DC,
  output logic               EN_EX,
  output logic               EN_MA,
  output logic               EN_WB,
  output logic               instret,
  output logic [STAGE_W-1:0] stage,
  output logic               halted,
  output logic [15:0]        stall_cnt
);

  logic tick;

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  stage_e      state_q, state_d;
  logic        en_ft_q, en_ft_d;
  logic        en_dc_q, en_dc_d;
  logic        en_ex_q, en_ex_d;
  logic        en_ma_q, en_ma_d;
  logic        en_wb_q, en_wb_d;
  logic        mem_req_q, mem_is_fetch_q, halted_q;
  logic        stall_inc;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Next-state and completion decode. Nothing moves except on tick.
  always_comb begin
    state_d   = state_q;
    en_ft_d   = 1'b0;
    en_dc_d   = 1'b0;
    en_ex_d   = 1'b0;
    en_ma_d   = 1'b0;
    en_wb_d   = 1'b0;
    stall_inc = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_FT;
        end
        ST_FT: begin
          if (memWait) begin
            stall_inc = 1'b1;
          end else begin
            en_ft_d = 1'b1;
            state_d = ST_DC;
          end
        end
        ST_DC: begin
          en_dc_d = 1'b1;
          state_d = ST_EX;
        end
        ST_EX: begin
          en_ex_d = 1'b1;
          state_d = rwmem ? ST_MA : ST_WB;
        end
        ST_MA: begin
          if (memWait) begin
            stall_inc = 1'b1;
          end else begin
            en_ma_d = 1'b1;
            state_d = ST_WB;
          end
        end
        ST_WB: begin
          en_wb_d = 1'b1;
          if (halt_req)  state_d = ST_HALT;
          else if (!run) state_d = ST_IDLE;
          else           state_d = ST_FT;
        end
        ST_HALT: begin
          if (!halt_req) state_d = run ? ST_FT : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State-derived outputs are registered from state_d so they line up with
  // state_q rather than trailing it by a cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      en_ft_q        <= 1'b0;
      en_dc_q        <= 1'b0;
      en_ex_q        <= 1'b0;
      en_ma_q        <= 1'b0;
      en_wb_q        <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_is_fetch_q <= 1'b0;
      halted_q       <= 1'b0;
      stall_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      en_ft_q        <= en_ft_d;
      en_dc_q        <= en_dc_d;
      en_ex_q        <= en_ex_d;
      en_ma_q        <= en_ma_d;
      en_wb_q        <= en_wb_d;
      mem_req_q      <= (state_d == ST_FT) || (state_d == ST_MA);
      mem_is_fetch_q <= (state_d == ST_FT);
      halted_q       <= (state_d == ST_HALT);
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign EN_FT        = en_ft_q;
  assign EN_DC        = en_dc_q;
  assign EN_EX        = en_ex_q;
  assign EN_MA        = en_ma_q;
  assign EN_WB        = en_wb_q;
  assign instret      = en_wb_q;
  assign mem_req      = mem_req_q;
  assign mem_is_fetch = mem_is_fetch_q;
  assign halted       = halted_q;
  assign stage        = state_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a DIV=1 instance for the main cases and
// a DIV=4 instance sharing the same inputs for tick spacing.
module tb_stage_sequencer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic run = 1'b0, halt_req = 1'b0, memWait = 1'b0, rwmem = 1'b0;

  logic        mem_req, mem_is_fetch, EN_FT, EN_DC, EN_EX, EN_MA, EN_WB;
  logic        instret, halted;
  logic [2:0]  stage;
  logic [15:0] stall_cnt;

  logic        mem_req4, mem_is_fetch4, EN_FT4, EN_DC4, EN_EX4, EN_MA4, EN_WB4;
  logic        instret4, halted4;
  logic [2:0]  stage4;
  logic [15:0] stall_cnt4;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  stage_sequencer #(.DIV(1), .DIV_W(24)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .run(run), .halt_req(halt_req),
    .memWait(memWait), .rwmem(rwmem), .mem_req(mem_req),
    .mem_is_fetch(mem_is_fetch), .EN_FT(EN_FT), .EN_DC(EN_DC), .EN_EX(EN_EX),
    .EN_MA(EN_MA), .EN_WB(EN_WB), .instret(instret), .stage(stage),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  stage_sequencer #(.DIV(4), .DIV_W(24)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .run(run), .halt_req(halt_req),
    .memWait(memWait), .rwmem(rwmem), .mem_req(mem_req4),
    .mem_is_fetch(mem_is_fetch4), .EN_FT(EN_FT4), .EN_DC(EN_DC4), .EN_EX(EN_EX4),
    .EN_MA(EN_MA4), .EN_WB(EN_WB4), .instret(instret4), .stage(stage4),
    .halted(halted4), .stall_cnt(stall_cnt4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=%0h", tag, obs);
    end
  endtask

  // One clock, sample on the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    run = 1'b0; halt_req = 1'b0; memWait = 1'b0; rwmem = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic logic [4:0] en1();
    return {EN_FT, EN_DC, EN_EX, EN_MA, EN_WB};
  endfunction

  initial begin
    logic [4:0] exp_en;
    logic [2:0] exp_st;
    int         n_ret;
    int         n_ma;
    int         ft_at, dc_at, ex_at, wb_at;
    int         cnt_ft, cnt_dc, cnt_ex, cnt_ma, cnt_wb, cnt_ret;
    bit         seen;

    // ---- reset state ----
    @(negedge CLK);
    check_val("rst_stage", {29'd0, stage}, 32'd0);
    check_val("rst_en", {27'd0, en1()}, 32'd0);
    check_val("rst_memreq", {30'd0, mem_req, mem_is_fetch}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_stall", {16'd0, stall_cnt}, 32'd0);

    // ---- 3 back-to-back ALU instructions, DIV=1 ----
    do_reset();
    run = 1'b1;
    step();
    check_val("t1_ft_stage", {29'd0, stage}, 32'd1);
    check_val("t1_ft_mem", {30'd0, mem_req, mem_is_fetch}, 32'd3);
    n_ret = 0; n_ma = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      case (k % 4)
        1: begin exp_en = 5'b10000; exp_st = 3'd2; end
        2: begin exp_en = 5'b01000; exp_st = 3'd3; end
        3: begin exp_en = 5'b00100; exp_st = 3'd5; end
        default: begin exp_en = 5'b00001; exp_st = 3'd1; end
      endcase
      check_val($sformatf("t1_en_%0d", k), {27'd0, en1()}, {27'd0, exp_en});
      check_val($sformatf("t1_st_%0d", k), {29'd0, stage}, {29'd0, exp_st});
      if (instret) n_ret++;
      if (EN_MA) n_ma++;
    end
    check_val("t1_instret", n_ret, 3);
    check_val("t1_no_ma", n_ma, 0);
    check_val("t1_stall", {16'd0, stall_cnt}, 32'd0);

    // ---- load/store with 3 MA stall ticks ----
    do_reset();
    run = 1'b1; rwmem = 1'b1;
    step(); step(); step();            // FT, DC, EX
    check_val("t2_ex", {29'd0, stage}, 32'd3);
    memWait = 1'b1;
    step();
    check_val("t2_ma_en", {27'd0, en1()}, 32'b00100);
    check_val("t2_ma_mem0", {30'd0, mem_req, mem_is_fetch}, 32'd2);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_val($sformatf("t2_hold_%0d", k), {26'd0, mem_req, mem_is_fetch, stage, EN_MA},
                {26'd0, 1'b1, 1'b0, 3'd4, 1'b0});
    end
    memWait = 1'b0;
    step();
    check_val("t2_en_ma", {27'd0, en1()}, 32'b00010);
    check_val("t2_wb_mem", {30'd0, mem_req, mem_is_fetch}, 32'd0);
    step();
    check_val("t2_en_wb", {26'd0, en1(), instret}, {26'd0, 5'b00001, 1'b1});
    check_val("t2_stall", {16'd0, stall_cnt}, 32'd3);

    // ---- run dropped during EX ----
    do_reset();
    run = 1'b1; rwmem = 1'b0;
    step(); step(); step();            // FT, DC, EX
    run = 1'b0;
    step();
    check_val("t3_wb", {29'd0, stage}, 32'd5);
    step();
    check_val("t3_en_wb", {26'd0, en1(), instret}, {26'd0, 5'b00001, 1'b1});
    check_val("t3_idle", {29'd0, stage}, 32'd0);
    step(); step();
    check_val("t3_quiet", {24'd0, en1(), stage}, 32'd0);

    // ---- halt requested during DC ----
    do_reset();
    run = 1'b1;
    step(); step();                    // FT, DC
    halt_req = 1'b1;
    step(); step();                    // EX, WB
    step();
    check_val("t4_ret", {31'd0, instret}, 32'd1);
    check_val("t4_halt", {28'd0, stage, halted}, {28'd0, 3'd6, 1'b1});
    step();
    check_val("t4_hold", {28'd0, stage, halted}, {28'd0, 3'd6, 1'b1});
    halt_req = 1'b0;
    step();
    check_val("t4_resume", {27'd0, stage, halted, mem_req}, {27'd0, 3'd1, 1'b0, 1'b1});

    // ---- async reset while stalled in MA ----
    do_reset();
    run = 1'b1; rwmem = 1'b1;
    step(); step(); step();            // FT, DC, EX
    memWait = 1'b1;
    step(); step();                    // MA, one stall
    check_val("t5_pre", {16'd0, stall_cnt}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_val("t5_async", {24'd0, stage, mem_req, mem_is_fetch, halted, instret, EN_MA}, 32'd0);
    check_val("t5_stall0", {16'd0, stall_cnt}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1; run = 1'b0; memWait = 1'b0;
    n_ma = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (EN_MA || EN_WB || stage != 3'd0) n_ma++;
    end
    check_val("t5_no_resume", n_ma, 0);

    // ---- stall counting over 300 FT ticks, then saturation ----
    do_reset();
    run = 1'b1; memWait = 1'b1;
    step();
    for (int k = 0; k < 300; k++) step();
    check_val("t6_stall300", {16'd0, stall_cnt}, 32'd300);
    force dut1.stall_cnt_q = 16'hFFFD;
    #1;
    release dut1.stall_cnt_q;
    step();
    check_val("t6_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    step();
    check_val("t6_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    step(); step();
    check_val("t6_sat", {16'd0, stall_cnt}, 32'hFFFF);

    // ---- DIV=4: one instruction, pulses 4 cycles apart ----
    do_reset();
    run = 1'b1;
    ft_at = -1; dc_at = -1; ex_at = -1; wb_at = -1;
    cnt_ft = 0; cnt_dc = 0; cnt_ex = 0; cnt_ma = 0; cnt_wb = 0; cnt_ret = 0;
    seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (!seen && stage4 == 3'd1) begin
        seen = 1'b1;
        check_val("t7_ft_entry", c, 4);
        run = 1'b0;
      end
      if (EN_FT4) begin cnt_ft++; ft_at = c; end
      if (EN_DC4) begin cnt_dc++; dc_at = c; end
      if (EN_EX4) begin cnt_ex++; ex_at = c; end
      if (EN_MA4) cnt_ma++;
      if (EN_WB4) begin cnt_wb++; wb_at = c; end
      if (instret4) cnt_ret++;
    end
    check_val("t7_entered_ft", {31'd0, seen}, 32'd1);
    check_val("t7_ft_at", ft_at, 8);
    check_val("t7_dc_gap", dc_at - ft_at, 4);
    check_val("t7_ex_gap", ex_at - dc_at, 4);
    check_val("t7_wb_gap", wb_at - ex_at, 4);
    check_val("t7_widths", {cnt_ft[7:0], cnt_dc[7:0], cnt_ex[7:0], cnt_wb[7:0]}, 32'h01010101);
    check_val("t7_no_ma", cnt_ma, 0);
    check_val("t7_instret", cnt_ret, 1);
    check_val("t7_idle", {29'd0, stage4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
